ssd_scan_ctl: RTL and testbench

Four-digit seven-segment scan controller for the board display. It time-multiplexes a 16-bit hex value onto the shared segment bus, one digit at a time, driving the active-low digit enables and the active-low segment/dot lines. The block decodes each digit internally and double-buffers the displayed value so that new values commit only on a frame boundary, which prevents tearing. It sits between the lab datapath, which produces values, and the board display pins.

---
 rtl/ssd_scan_ctl_if.sv | 23 ++
 rtl/ssd_scan_ctl.sv | 108 ++++++++++
 tb/tb_ssd_scan_ctl.sv | 309 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ssd_scan_ctl_if.sv
// rtl/ssd_scan_ctl_if.sv - datapath-to-display bundle for the seven-segment scan controller
interface ssd_scan_ctl_if;
  logic        en;
  logic        load;
  logic [15:0] data_in;
  logic [3:0]  dp_in;
  logic        lzb;
  logic [3:0]  ssd_ctl;
  logic [7:0]  D_ssd;
  logic [3:0]  d;
  logic        pending;
  logic        frame_tick;

  modport master (
    output en, load, data_in, dp_in, lzb,
    input  ssd_ctl, D_ssd, d, pending, frame_tick
  );

  modport slave (
    input  en, load, data_in, dp_in, lzb,
    output ssd_ctl, D_ssd, d, pending, frame_tick
  );
endinterface

// File: rtl/ssd_scan_ctl.sv
// rtl/ssd_scan_ctl.sv - four-digit seven-segment scanner with frame-boundary double buffering
module ssd_scan_ctl #(
  parameter int DIV = 100000
) (
  input  logic          clk,
  input  logic          rst,
  ssd_scan_ctl_if.slave bus
);
  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CW-1:0] cnt;
  logic [1:0]    idx;
  logic [15:0]   shadow;
  logic [15:0]   active;
  logic          pend;

  logic          slot_end;
  logic          commit;
  logic [3:0]    nib;
  logic          blank;
  logic          z3, z2, z1;

  function automatic logic [6:0] seg7(input logic [3:0] v);
    case (v)
      4'h0: seg7 = 7'b0000001;
      4'h1: seg7 = 7'b1001111;
      4'h2: seg7 = 7'b0010010;
      4'h3: seg7 = 7'b0000110;
      4'h4: seg7 = 7'b1001100;
      4'h5: seg7 = 7'b0100100;
      4'h6: seg7 = 7'b0100000;
      4'h7: seg7 = 7'b0001111;
      4'h8: seg7 = 7'b0000000;
      4'h9: seg7 = 7'b0000100;
      4'hA: seg7 = 7'b0001000;
      4'hB: seg7 = 7'b1100000;
      4'hC: seg7 = 7'b0110001;
      4'hD: seg7 = 7'b1000010;
      4'hE: seg7 = 7'b0110000;
      default: seg7 = 7'b0111000;
    endcase
  endfunction

  always_comb begin
    slot_end = (cnt == CW'(DIV - 1));
    commit   = bus.en && slot_end && (idx == 2'd3);
    case (idx)
      2'd0:    nib = active[3:0];
      2'd1:    nib = active[7:4];
      2'd2:    nib = active[11:8];
      default: nib = active[15:12];
    endcase
    // A digit is a leading zero only if it and everything to its left is zero.
    z3 = (active[15:12] == 4'h0);
    z2 = z3 && (active[11:8] == 4'h0);
    z1 = z2 && (active[7:4] == 4'h0);
    case (idx)
      2'd1:    blank = bus.lzb && z1;
      2'd2:    blank = bus.lzb && z2;
      2'd3:    blank = bus.lzb && z3;
      default: blank = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt            <= '0;
      idx            <= 2'd0;
      shadow         <= 16'h0000;
      active         <= 16'h0000;
      pend           <= 1'b0;
      bus.ssd_ctl    <= 4'b1111;
      bus.D_ssd      <= 8'hFF;
      bus.d          <= 4'h0;
      bus.pending    <= 1'b0;
      bus.frame_tick <= 1'b0;
    end else begin
      if (bus.load) begin
        shadow <= bus.data_in;
        pend   <= 1'b1;
      end
      if (bus.en) begin
        if (slot_end) begin
          cnt <= '0;
          idx <= idx + 2'd1;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end
      // A load landing on the commit edge bypasses the shadow so no stale frame is shown.
      if (commit && (pend || bus.load)) begin
        active <= bus.load ? bus.data_in : shadow;
        pend   <= 1'b0;
      end
      bus.frame_tick <= commit;
      bus.pending    <= pend;
      if (bus.en) begin
        bus.ssd_ctl <= ~(4'b0001 << idx);
        bus.D_ssd   <= {blank ? 7'h7F : seg7(nib), ~bus.dp_in[idx]};
        bus.d       <= nib;
      end else begin
        bus.ssd_ctl <= 4'b1111;
        bus.D_ssd   <= 8'hFF;
        bus.d       <= 4'h0;
      end
    end
  end
endmodule

// File: tb/tb_ssd_scan_ctl.sv
// tb/tb_ssd_scan_ctl.sv - directed self-checking bench for ssd_scan_ctl with DIV=4
module tb_ssd_scan_ctl;
  logic clk;
  logic rst;
  int   checks;
  int   failures;

  ssd_scan_ctl_if bus ();

  ssd_scan_ctl #(.DIV(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_tick(input string name);
    int n;
    step();
    n = 1;
    while (bus.frame_tick !== 1'b1 && n < 200) begin
      step();
      n++;
    end
    checks++;
    if (bus.frame_tick !== 1'b1) begin
      failures++;
      $display("FAIL %s_tick_timeout frame_tick=%b expected 1 within 200 cycles", name, bus.frame_tick);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    checks++;
    if (bus.ssd_ctl !== 4'b1111 || bus.D_ssd !== 8'hFF || bus.d !== 4'h0 ||
        bus.pending !== 1'b0 || bus.frame_tick !== 1'b0) begin
      failures++;
      $display("FAIL reset_state ctl=%b seg=%h d=%h pend=%b tick=%b expected 1111 ff 0 0 0",
               bus.ssd_ctl, bus.D_ssd, bus.d, bus.pending, bus.frame_tick);
    end
    rst = 1'b0;
    #2;
    checks++;
    if (bus.ssd_ctl !== 4'b1111 || bus.D_ssd !== 8'hFF) begin
      failures++;
      $display("FAIL reset_first_cycle ctl=%b seg=%h expected 1111 ff", bus.ssd_ctl, bus.D_ssd);
    end
    @(posedge clk);
    #1;
    checks++;
    if (bus.ssd_ctl !== 4'b1110 || bus.D_ssd !== 8'h03 || bus.d !== 4'h0) begin
      failures++;
      $display("FAIL reset_second_cycle ctl=%b seg=%h d=%h expected 1110 03 0",
               bus.ssd_ctl, bus.D_ssd, bus.d);
    end
  endtask

  task automatic test_scan();
    logic [7:0] exp_seg [4];
    logic [3:0] exp_d   [4];
    int k;
    exp_seg = '{8'h99, 8'h0D, 8'h25, 8'h9F};
    exp_d   = '{4'h4, 4'h3, 4'h2, 4'h1};
    bus.load = 1'b1;
    bus.data_in = 16'h1234;
    step();
    bus.load = 1'b0;
    step();
    checks++;
    if (bus.pending !== 1'b1) begin
      failures++;
      $display("FAIL scan_pending pending=%b expected 1", bus.pending);
    end
    wait_tick("scan");
    for (int i = 0; i < 16; i++) begin
      step();
      k = i / 4;
      checks++;
      if (bus.ssd_ctl !== (4'b1111 ^ (4'b0001 << k)) || bus.D_ssd !== exp_seg[k] || bus.d !== exp_d[k]) begin
        failures++;
        $display("FAIL scan_frame i=%0d ctl=%b seg=%h d=%h expected %b %h %h", i,
                 bus.ssd_ctl, bus.D_ssd, bus.d, 4'b1111 ^ (4'b0001 << k), exp_seg[k], exp_d[k]);
      end
    end
    checks++;
    if (bus.frame_tick !== 1'b1) begin
      failures++;
      $display("FAIL scan_frame_period frame_tick=%b expected 1 after 16 cycles", bus.frame_tick);
    end
  endtask

  task automatic test_tear_free();
    int n;
    int bad;
    int k;
    for (int i = 0; i < 6; i++) step();
    bus.load = 1'b1;
    bus.data_in = 16'h8888;
    step();
    bus.load = 1'b0;
    step();
    checks++;
    if (bus.pending !== 1'b1) begin
      failures++;
      $display("FAIL tear_pending pending=%b expected 1", bus.pending);
    end
    bad = 0;
    n = 0;
    while (bus.frame_tick !== 1'b1 && n < 100) begin
      step();
      n++;
      if (bus.d === 4'h8 || bus.D_ssd === 8'h01) bad++;
    end
    checks++;
    if (bus.frame_tick !== 1'b1 || bad !== 0) begin
      failures++;
      $display("FAIL tear_before_tick tick=%b early_new_digits=%0d expected 1 0", bus.frame_tick, bad);
    end
    checks++;
    if (bus.d !== 4'h1 || bus.pending !== 1'b1) begin
      failures++;
      $display("FAIL tear_tick_cycle d=%h pending=%b expected 1 1", bus.d, bus.pending);
    end
    for (int i = 0; i < 16; i++) begin
      step();
      k = i / 4;
      checks++;
      if (bus.ssd_ctl !== (4'b1111 ^ (4'b0001 << k)) || bus.D_ssd !== 8'h01 ||
          bus.d !== 4'h8 || bus.pending !== 1'b0) begin
        failures++;
        $display("FAIL tear_new_frame i=%0d ctl=%b seg=%h d=%h pend=%b expected %b 01 8 0", i,
                 bus.ssd_ctl, bus.D_ssd, bus.d, bus.pending, 4'b1111 ^ (4'b0001 << k));
      end
    end
  endtask

  task automatic test_load_on_commit();
    logic [7:0] exp_seg [4];
    logic [3:0] exp_d   [4];
    int k;
    exp_seg = '{8'h85, 8'h63, 8'hC1, 8'h11};
    exp_d   = '{4'hD, 4'hC, 4'hB, 4'hA};
    for (int i = 0; i < 15; i++) step();
    bus.load = 1'b1;
    bus.data_in = 16'hABCD;
    step();
    bus.load = 1'b0;
    checks++;
    if (bus.frame_tick !== 1'b1 || bus.pending !== 1'b0) begin
      failures++;
      $display("FAIL commit_load_edge tick=%b pending=%b expected 1 0", bus.frame_tick, bus.pending);
    end
    for (int i = 0; i < 16; i++) begin
      step();
      k = i / 4;
      checks++;
      if (bus.ssd_ctl !== (4'b1111 ^ (4'b0001 << k)) || bus.D_ssd !== exp_seg[k] ||
          bus.d !== exp_d[k] || bus.pending !== 1'b0) begin
        failures++;
        $display("FAIL commit_load_frame i=%0d ctl=%b seg=%h d=%h pend=%b expected %b %h %h 0", i,
                 bus.ssd_ctl, bus.D_ssd, bus.d, bus.pending, 4'b1111 ^ (4'b0001 << k), exp_seg[k], exp_d[k]);
      end
    end
  endtask

  task automatic test_lzb();
    logic [7:0] seg_on  [4];
    logic [7:0] seg_off [4];
    int k;
    seg_on  = '{8'h03, 8'h49, 8'hFF, 8'hFE};
    seg_off = '{8'h03, 8'h49, 8'h03, 8'h02};
    bus.lzb = 1'b1;
    bus.dp_in = 4'b1000;
    bus.load = 1'b1;
    bus.data_in = 16'h0050;
    step();
    bus.load = 1'b0;
    wait_tick("lzb");
    for (int i = 0; i < 16; i++) begin
      step();
      k = i / 4;
      checks++;
      if (bus.ssd_ctl !== (4'b1111 ^ (4'b0001 << k)) || bus.D_ssd !== seg_on[k]) begin
        failures++;
        $display("FAIL lzb_on i=%0d ctl=%b seg=%h expected %b %h", i,
                 bus.ssd_ctl, bus.D_ssd, 4'b1111 ^ (4'b0001 << k), seg_on[k]);
      end
    end
    bus.lzb = 1'b0;
    for (int i = 0; i < 16; i++) begin
      step();
      k = i / 4;
      checks++;
      if (bus.ssd_ctl !== (4'b1111 ^ (4'b0001 << k)) || bus.D_ssd !== seg_off[k]) begin
        failures++;
        $display("FAIL lzb_off i=%0d ctl=%b seg=%h expected %b %h", i,
                 bus.ssd_ctl, bus.D_ssd, 4'b1111 ^ (4'b0001 << k), seg_off[k]);
      end
    end
    bus.dp_in = 4'b0000;
  endtask

  task automatic test_enable();
    int ticks;
    step();
    step();
    bus.en = 1'b0;
    bus.load = 1'b1;
    bus.data_in = 16'h4321;
    ticks = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      bus.load = 1'b0;
      if (bus.frame_tick === 1'b1) ticks++;
      checks++;
      if (bus.ssd_ctl !== 4'b1111 || bus.D_ssd !== 8'hFF) begin
        failures++;
        $display("FAIL enable_blank i=%0d ctl=%b seg=%h expected 1111 ff", i, bus.ssd_ctl, bus.D_ssd);
      end
    end
    checks++;
    if (bus.pending !== 1'b1 || ticks !== 0) begin
      failures++;
      $display("FAIL enable_load_capture pending=%b ticks=%0d expected 1 0", bus.pending, ticks);
    end
    bus.en = 1'b1;
    step();
    checks++;
    if (bus.ssd_ctl !== 4'b1110 || bus.D_ssd !== 8'h03) begin
      failures++;
      $display("FAIL enable_resume_0 ctl=%b seg=%h expected 1110 03", bus.ssd_ctl, bus.D_ssd);
    end
    step();
    checks++;
    if (bus.ssd_ctl !== 4'b1110 || bus.frame_tick !== 1'b0) begin
      failures++;
      $display("FAIL enable_resume_1 ctl=%b tick=%b expected 1110 0", bus.ssd_ctl, bus.frame_tick);
    end
    step();
    checks++;
    if (bus.ssd_ctl !== 4'b1101 || bus.D_ssd !== 8'h49) begin
      failures++;
      $display("FAIL enable_resume_2 ctl=%b seg=%h expected 1101 49", bus.ssd_ctl, bus.D_ssd);
    end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 4; i++) step();
    checks++;
    if (bus.ssd_ctl !== 4'b1011 || bus.pending !== 1'b1) begin
      failures++;
      $display("FAIL midreset_setup ctl=%b pending=%b expected 1011 1", bus.ssd_ctl, bus.pending);
    end
    rst = 1'b1;
    step();
    checks++;
    if (bus.ssd_ctl !== 4'b1111 || bus.D_ssd !== 8'hFF || bus.d !== 4'h0 ||
        bus.pending !== 1'b0 || bus.frame_tick !== 1'b0) begin
      failures++;
      $display("FAIL midreset_state ctl=%b seg=%h d=%h pend=%b tick=%b expected 1111 ff 0 0 0",
               bus.ssd_ctl, bus.D_ssd, bus.d, bus.pending, bus.frame_tick);
    end
    rst = 1'b0;
    step();
    checks++;
    if (bus.ssd_ctl !== 4'b1110 || bus.D_ssd !== 8'h03 || bus.d !== 4'h0) begin
      failures++;
      $display("FAIL midreset_restart ctl=%b seg=%h d=%h expected 1110 03 0",
               bus.ssd_ctl, bus.D_ssd, bus.d);
    end
    wait_tick("midreset");
    step();
    checks++;
    if (bus.d !== 4'h0 || bus.D_ssd !== 8'h03 || bus.pending !== 1'b0) begin
      failures++;
      $display("FAIL midreset_shadow_lost d=%h seg=%h pending=%b expected 0 03 0",
               bus.d, bus.D_ssd, bus.pending);
    end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    rst = 1'b1;
    bus.en = 1'b1;
    bus.load = 1'b0;
    bus.data_in = 16'h0000;
    bus.dp_in = 4'b0000;
    bus.lzb = 1'b0;
    test_reset();
    test_scan();
    test_tear_free();
    test_load_on_commit();
    test_lzb();
    test_enable();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
